// File: rtl/mips_loader_pkg.sv
// rtl/mips_loader_pkg.sv - shared states and framing constants for the IMEM stream loader
//
// Imported by imem_stream_loader and byte_word_packer.
//   state_t    : loader states HDR, DATA, CSUM, DONE, ERR
//   LEN_BYTES  : bytes in the big-endian length header
//   WORD_BYTES : bytes per instruction word
//   CSUM_W     : width of the payload checksum

package mips_loader_pkg;

    typedef enum logic [2:0] {
        HDR  = 3'd0,
        DATA = 3'd1,
        CSUM = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    localparam int LEN_BYTES  = 4;
    localparam int WORD_BYTES = 4;
    localparam int CSUM_W     = 8;

endpackage

// File: rtl/byte_word_packer.sv
// rtl/byte_word_packer.sv - packs big-endian bytes into 32-bit words
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   clear       : drops any partially packed word (priority over shift_en)
//   shift_en    : byte_in is shifted in this cycle
//   byte_in     : incoming byte, first byte of a word ends up in [31:24]
//   word_valid  : combinational; high in the cycle the last byte of a word shifts in
//   word        : the completed word, valid together with word_valid

module byte_word_packer
    import mips_loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        shift_en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);

    logic [1:0]  cnt;
    logic [23:0] acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            acc <= '0;
        end else if (clear) begin
            cnt <= '0;
            acc <= '0;
        end else if (shift_en) begin
            acc <= {acc[15:0], byte_in};
            cnt <= cnt + 2'd1;
        end
    end

    // The word completes with the current byte, so it is presented without
    // waiting for the shift register to absorb it.
    assign word_valid = shift_en && !clear && (cnt == 2'(WORD_BYTES - 1));
    assign word       = {acc, byte_in};

endmodule

// File: rtl/imem_stream_loader.sv
// rtl/imem_stream_loader.sv - loads a length-prefixed byte stream into IMEM and releases the core
//
// Optional feature macro: IMEM_LOADER_CSUM_EN (trailing payload checksum byte).
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   reload      : one-cycle pulse, restarts the load (wins over a same-cycle transfer)
//   in_valid    : stream byte valid
//   in_data     : stream byte
//   in_ready    : loader accepts a byte this cycle
//   imem_we     : single-cycle IMEM write strobe
//   imem_addr   : IMEM word address
//   imem_wdata  : IMEM write data
//   cpu_hold    : core stall, low only once the image is loaded
//   done        : image loaded (and checksum matched when enabled)
//   error       : oversize length or checksum mismatch

module imem_stream_loader
    import mips_loader_pkg::*;
#(
    parameter int IMEM_AW   = 6,
    parameter int BASE_ADDR = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               reload,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [31:0]        imem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               error
);

    // Words that fit between BASE_ADDR and the top of IMEM; 33 bits so the
    // 32-bit length compares without wrapping.
    localparam logic [32:0] MAX_WORDS = 33'((64'd1 << IMEM_AW) - 64'(BASE_ADDR));
    localparam logic [IMEM_AW-1:0] BASE = IMEM_AW'(BASE_ADDR);

`ifdef IMEM_LOADER_CSUM_EN
    localparam state_t AFTER_DATA = CSUM;
    logic [CSUM_W-1:0] csum;
`else
    localparam state_t AFTER_DATA = DONE;
`endif

    state_t      state, state_nx;
    logic        run_q;
    logic [31:0] len_q;
    logic [31:0] word_cnt;
    logic        data_full;
    logic        fire;
    logic        pk_shift;
    logic        pk_valid;
    logic [31:0] pk_word;

    // run_q keeps in_ready low while in reset and for the reset-release edge.
    assign data_full = (word_cnt == len_q);
    assign in_ready  = run_q && ((state == HDR) ||
                                 (state == DATA && !data_full) ||
                                 (state == CSUM));
    assign fire      = in_valid && in_ready && !reload;
    assign pk_shift  = fire && (state == HDR || state == DATA);

    // The header length and payload words share one packer.
    byte_word_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (reload),
        .shift_en   (pk_shift),
        .byte_in    (in_data),
        .word_valid (pk_valid),
        .word       (pk_word)
    );

    always_comb begin
        state_nx = state;
        case (state)
            HDR: begin
                if (pk_valid) begin
                    if ({1'b0, pk_word} > MAX_WORDS) state_nx = ERR;
                    else if (pk_word == 32'd0)       state_nx = AFTER_DATA;
                    else                             state_nx = DATA;
                end
            end
            DATA: begin
`ifdef IMEM_LOADER_CSUM_EN
                // Leave on the last word so the checksum byte is never blocked.
                if (pk_valid && (word_cnt + 32'd1 == len_q)) state_nx = CSUM;
`else
                // Stay until the last strobe has gone out.
                if (data_full && imem_we) state_nx = DONE;
`endif
            end
            CSUM: begin
`ifdef IMEM_LOADER_CSUM_EN
                if (fire) state_nx = (in_data == csum) ? DONE : ERR;
`endif
            end
            default: state_nx = state;
        endcase
        if (reload) state_nx = HDR;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= HDR;
            run_q      <= 1'b0;
            len_q      <= '0;
            word_cnt   <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= BASE;
            imem_wdata <= '0;
`ifdef IMEM_LOADER_CSUM_EN
            csum       <= '0;
`endif
        end else begin
            run_q   <= 1'b1;
            state   <= state_nx;
            imem_we <= 1'b0;
            if (reload) begin
                len_q     <= '0;
                word_cnt  <= '0;
                imem_addr <= BASE;
`ifdef IMEM_LOADER_CSUM_EN
                csum      <= '0;
`endif
            end else begin
                // Address moves on only after the strobe cycle has used it.
                if (imem_we) imem_addr <= imem_addr + 1'b1;
                if (state == HDR && pk_valid) len_q <= pk_word;
                if (state == DATA && pk_valid) begin
                    imem_wdata <= pk_word;
                    imem_we    <= 1'b1;
                    word_cnt   <= word_cnt + 32'd1;
                end
`ifdef IMEM_LOADER_CSUM_EN
                if (state == DATA && fire) csum <= csum + in_data;
`endif
            end
        end
    end

    assign done     = (state == DONE);
    assign error    = (state == ERR);
    assign cpu_hold = (state != DONE);

endmodule

// File: tb/tb_imem_stream_loader.sv
// tb/tb_imem_stream_loader.sv - self-checking bench for imem_stream_loader

module tb_imem_stream_loader;

    localparam int AW    = 6;
    localparam int BASE  = 0;
    localparam int DEPTH = 1 << AW;
    localparam logic [31:0] SENT = 32'hDEADBEEF;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          reload = 1'b0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          done;
    logic          error;

    imem_stream_loader #(.IMEM_AW(AW), .BASE_ADDR(BASE)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .reload     (reload),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0]   mem_seen [DEPTH];
    logic [31:0]   mem_exp  [DEPTH];
    int            we_count;
    int            we_double;
    logic          prev_we;
    logic [AW-1:0] addr_log [$];
    logic [31:0]   words_q  [$];
    logic [7:0]    frame_q  [$];

    // IMEM stand-in: record every strobe, and catch strobes longer than a cycle.
    always @(negedge clk) begin
        if (imem_we) begin
            mem_seen[imem_addr] = imem_wdata;
            we_count++;
            addr_log.push_back(imem_addr);
            if (prev_we) we_double++;
        end
        prev_we = imem_we;
    end

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            mem_seen[i] = SENT;
            mem_exp[i]  = SENT;
        end
        we_count  = 0;
        we_double = 0;
        prev_we   = 1'b0;
        addr_log.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0; reload = 1'b0; in_valid = 1'b0;
        repeat (2) @(negedge clk);
        clear_model();
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Reference framing: length header, big-endian words, checksum over payload only.
    task automatic build_frame(input logic [31:0] n, input bit hdr_only);
        logic [7:0] sum;
        sum = 8'h00;
        frame_q.delete();
        for (int i = 3; i >= 0; i--) frame_q.push_back(8'((n >> (8 * i)) & 32'hFF));
        if (!hdr_only) begin
            for (int w = 0; w < words_q.size(); w++) begin
                for (int i = 3; i >= 0; i--) begin
                    frame_q.push_back(8'((words_q[w] >> (8 * i)) & 32'hFF));
                    sum = 8'((int'(sum) + int'((words_q[w] >> (8 * i)) & 32'hFF)) % 256);
                end
                mem_exp[(BASE + w) % DEPTH] = words_q[w];
            end
`ifdef IMEM_LOADER_CSUM_EN
            frame_q.push_back(sum);
`endif
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gap);
        int t;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready=%0b required 1", in_ready);
        end else begin
            in_valid = 1'b1;
            in_data  = b;
            @(negedge clk);
            in_valid = 1'b0;
            if (gap) @(negedge clk);
        end
    endtask

    task automatic send_frame(input bit gap);
        for (int i = 0; i < frame_q.size(); i++) send_byte(frame_q[i], gap);
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(done || error) && t < 200) begin
            @(negedge clk);
            t++;
        end
        total++;
        if (!(done || error)) begin
            bad++;
            $display("FAIL wait_end: done=%0b error=%0b required one high", done, error);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; reload = 1'b0;
        repeat (2) @(negedge clk);
        total++; if (in_ready !== 1'b0)  begin bad++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
        total++; if (imem_we !== 1'b0)   begin bad++; $display("FAIL rst_we: got %0b want 0", imem_we); end
        total++; if (imem_addr !== AW'(BASE)) begin bad++; $display("FAIL rst_addr: got %0d want %0d", imem_addr, BASE); end
        total++; if (imem_wdata !== 32'h0) begin bad++; $display("FAIL rst_wdata: got %h want 0", imem_wdata); end
        total++; if (cpu_hold !== 1'b1)  begin bad++; $display("FAIL rst_hold: got %0b want 1", cpu_hold); end
        total++; if (done !== 1'b0)      begin bad++; $display("FAIL rst_done: got %0b want 0", done); end
        total++; if (error !== 1'b0)     begin bad++; $display("FAIL rst_error: got %0b want 0", error); end
        clear_model();
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (in_ready !== 1'b1)  begin bad++; $display("FAIL post_rst_ready: got %0b want 1", in_ready); end
    endtask

    task automatic test_known_frame();
        do_reset();
        words_q.delete();
        words_q.push_back(32'h8C010000);
        words_q.push_back(32'h00221820);
        build_frame(32'd2, 1'b0);
        send_frame(1'b0);
        wait_end();
        total++; if (mem_seen[0] !== 32'h8C010000) begin bad++; $display("FAIL known_im0: got %h want 8c010000", mem_seen[0]); end
        total++; if (mem_seen[1] !== 32'h00221820) begin bad++; $display("FAIL known_im1: got %h want 00221820", mem_seen[1]); end
        total++; if (we_count !== 2 || we_double !== 0) begin bad++; $display("FAIL known_we: got %0d/%0d want 2/0", we_count, we_double); end
        total++; if (done !== 1'b1 || cpu_hold !== 1'b0 || error !== 1'b0) begin bad++; $display("FAIL known_status: done=%0b hold=%0b err=%0b want 1 0 0", done, cpu_hold, error); end
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL known_ready: got %0b want 0", in_ready); end
    endtask

`ifdef IMEM_LOADER_CSUM_EN
    task automatic test_bad_csum();
        do_reset();
        words_q.delete();
        words_q.push_back(32'h8C010000);
        words_q.push_back(32'h00221820);
        build_frame(32'd2, 1'b0);
        frame_q[frame_q.size() - 1] = 8'h00;
        send_frame(1'b0);
        wait_end();
        total++; if (error !== 1'b1 || done !== 1'b0 || cpu_hold !== 1'b1 || in_ready !== 1'b0) begin
            bad++; $display("FAIL badcsum_status: err=%0b done=%0b hold=%0b ready=%0b want 1 0 1 0", error, done, cpu_hold, in_ready); end
        total++; if (mem_seen[0] !== 32'h8C010000 || mem_seen[1] !== 32'h00221820) begin
            bad++; $display("FAIL badcsum_mem: got %h %h want 8c010000 00221820", mem_seen[0], mem_seen[1]); end
    endtask
`endif

    task automatic test_oversize();
        do_reset();
        words_q.delete();
        build_frame(32'(DEPTH - BASE + 1), 1'b1);
        send_frame(1'b0);
        total++; if (error !== 1'b1 || in_ready !== 1'b0 || cpu_hold !== 1'b1) begin
            bad++; $display("FAIL oversize_status: err=%0b ready=%0b hold=%0b want 1 0 1", error, in_ready, cpu_hold); end
        repeat (4) @(negedge clk);
        total++; if (we_count !== 0) begin bad++; $display("FAIL oversize_we: got %0d want 0", we_count); end
    endtask

    task automatic test_full_depth();
        int errs;
        do_reset();
        words_q.delete();
        for (int i = 0; i < DEPTH - BASE; i++) words_q.push_back($urandom);
        build_frame(32'(DEPTH - BASE), 1'b0);
        send_frame(1'b0);
        wait_end();
        errs = 0;
        for (int i = 0; i < DEPTH; i++) if (mem_seen[i] !== mem_exp[i]) errs++;
        total++; if (errs !== 0) begin bad++; $display("FAIL full_mem: %0d words differ want 0", errs); end
        total++; if (done !== 1'b1 || we_count !== DEPTH - BASE) begin bad++; $display("FAIL full_status: done=%0b we=%0d want 1 %0d", done, we_count, DEPTH - BASE); end
    endtask

    task automatic test_zero_len();
        do_reset();
        words_q.delete();
        build_frame(32'd0, 1'b0);
        send_frame(1'b0);
        wait_end();
        total++; if (done !== 1'b1 || error !== 1'b0 || cpu_hold !== 1'b0) begin bad++; $display("FAIL zero_status: done=%0b err=%0b hold=%0b want 1 0 0", done, error, cpu_hold); end
        total++; if (we_count !== 0) begin bad++; $display("FAIL zero_we: got %0d want 0", we_count); end
    endtask

    task automatic test_back_to_back();
        int n, errs;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            n = $urandom_range(1, 8);
            words_q.delete();
            for (int i = 0; i < n; i++) words_q.push_back($urandom);
            build_frame(32'(n), 1'b0);
            send_frame(1'b0);
            wait_end();
            errs = 0;
            for (int i = 0; i < DEPTH; i++) if (mem_seen[i] !== mem_exp[i]) errs++;
            total++; if (errs !== 0 || done !== 1'b1) begin bad++; $display("FAIL b2b_mem[%0d]: %0d diffs done=%0b want 0 1", r, errs, done); end
            total++; if (we_count !== n || we_double !== 0 || imem_addr !== AW'(BASE + n)) begin
                bad++; $display("FAIL b2b_we[%0d]: we=%0d dbl=%0d addr=%0d want %0d 0 %0d", r, we_count, we_double, imem_addr, n, BASE + n); end
        end
    endtask

    task automatic test_toggle();
        do_reset();
        words_q.delete();
        words_q.push_back(32'h8C010000);
        words_q.push_back(32'h00221820);
        build_frame(32'd2, 1'b0);
        send_frame(1'b1);
        wait_end();
        total++; if (mem_seen[0] !== 32'h8C010000 || mem_seen[1] !== 32'h00221820) begin
            bad++; $display("FAIL toggle_mem: got %h %h want 8c010000 00221820", mem_seen[0], mem_seen[1]); end
        total++; if (addr_log.size() !== 2) begin bad++; $display("FAIL toggle_nwrites: got %0d want 2", addr_log.size()); end
        else begin
            total++; if (addr_log[0] !== AW'(0) || addr_log[1] !== AW'(1)) begin bad++; $display("FAIL toggle_addr_seq: got %0d,%0d want 0,1", addr_log[0], addr_log[1]); end
        end
        total++; if (imem_addr !== AW'(2) || done !== 1'b1) begin bad++; $display("FAIL toggle_final: addr=%0d done=%0b want 2 1", imem_addr, done); end
    endtask

    task automatic test_reload();
        logic [31:0] new_word;
        do_reset();
        words_q.delete();
        words_q.push_back($urandom);
        words_q.push_back($urandom);
        build_frame(32'd2, 1'b0);
        for (int i = 0; i < 10; i++) send_byte(frame_q[i], 1'b0);
        // Transfer attempted in the reload cycle must be dropped.
        reload = 1'b1; in_valid = 1'b1; in_data = 8'h55;
        @(negedge clk);
        reload = 1'b0; in_valid = 1'b0;
        total++; if (in_ready !== 1'b1 || cpu_hold !== 1'b1 || imem_addr !== AW'(BASE)) begin
            bad++; $display("FAIL reload_state: ready=%0b hold=%0b addr=%0d want 1 1 %0d", in_ready, cpu_hold, imem_addr, BASE); end
        for (int i = 0; i < DEPTH; i++) mem_exp[i] = SENT;
        new_word = $urandom;
        words_q.delete();
        words_q.push_back(new_word);
        build_frame(32'd1, 1'b0);
        send_frame(1'b0);
        wait_end();
        total++; if (mem_seen[0] !== new_word) begin bad++; $display("FAIL reload_im0: got %h want %h", mem_seen[0], new_word); end
        total++; if (mem_seen[1] !== SENT || we_count !== 2) begin bad++; $display("FAIL reload_partial: im1=%h we=%0d want %h 2", mem_seen[1], we_count, SENT); end
        total++; if (done !== 1'b1 || error !== 1'b0) begin bad++; $display("FAIL reload_done: done=%0b err=%0b want 1 0", done, error); end
    endtask

    initial begin
        test_reset();
        test_known_frame();
`ifdef IMEM_LOADER_CSUM_EN
        test_bad_csum();
`endif
        test_oversize();
        test_full_depth();
        test_zero_len();
        test_back_to_back();
        test_toggle();
        test_reload();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
